closest_hit_reducer: RTL and testbench
======================================

// Module: closest_hit_reducer
// PURPOSE
//  Multi-lane closest-hit tracker for one ray batch. Sits after NLANES parallel intersection pipelines.
//  Each cycle it accepts up to NLANES tagged results (valid, hit, t, triangle index).
//  It filters them, reduces them to a per-cycle minimum in a 2-stage pipeline, and keeps a running minimum.
//  It signals batch completion once the programmed triangle count has been consumed.
// PARAMETERS
//  NLANES  4             lanes per cycle, power of 2, 1..16
//  IDX_W   32            triangle index / count width
//  MIN_T   0             smallest accepted t (signed Q16.16); t < MIN_T is a miss
//  MAX_T   32'sh7fffffff exclusive upper t bound; also the o_t value when there is no hit
// PORTS
//  i_clk        in   1             clock
//  i_rstn       in   1             synchronous active-low reset
//  i_start      in   1             1-cycle pulse; samples i_tri_cnt and opens a new batch
//  i_tri_cnt    in   IDX_W         number of results expected in the batch
//  i_valid      in   NLANES        per-lane result valid
//  i_hit        in   NLANES        per-lane intersection result
//  i_t          in   NLANES*32     per-lane t, signed Q16.16, lane k at [32k+31:32k]
//  i_idx        in   NLANES*IDX_W  per-lane triangle index
//  o_busy       out  1             batch open (RUN or DRAIN)
//  o_hit        out  1             at least one accepted hit in the batch
//  o_t          out  32            minimum accepted t; MAX_T if no hit
//  o_tri_index  out  IDX_W         index of the minimum-t triangle; 0 if no hit
//  o_finish     out  1             batch done; held high until the next i_start
//  o_err        out  1             sticky: results arrived while no batch was open, or beyond the count
// BEHAVIOUR
//  Reset: FSM=IDLE; o_busy, o_hit, o_finish, o_err = 0; o_t = MAX_T; o_tri_index = 0; pipeline valids cleared.
//  FSM states:
//   IDLE -> RUN on i_start.
//   RUN -> DRAIN when the consumed count reaches the expected count.
//   DRAIN -> DONE after 2 cycles, once the pipeline is empty.
//   DONE -> RUN on i_start.
//  i_start (any state):
//   - load remaining = i_tri_cnt; clear o_hit, o_finish, o_err; set o_t = MAX_T, o_tri_index = 0.
//   - flush in-flight pipeline stages; their results are discarded.
//   - lane inputs in the same cycle as i_start are ignored.
//  i_tri_cnt == 0: IDLE/DONE -> DONE next cycle, o_finish = 1, o_hit = 0.
//  Lane acceptance (RUN only):
//   - valid lanes are granted in ascending lane order while the grant count <= remaining.
//   - remaining -= granted count, every cycle.
//   - ungranted valid lanes are dropped and set o_err.
//   - any i_valid in IDLE, DRAIN or DONE sets o_err and is ignored.
//  Stage 1 (registered): candidate = granted & i_hit & (t >= MIN_T) & (t < MAX_T), signed compare.
//  Stage 2 (registered): combinational min tree over the candidates.
//   - tie on t: lower triangle index wins.
//   - no candidates in the cycle: stage-2 output is invalid for update purposes.
//  Running update: in the cycle after stage 2, if stage-2 t < o_t, or equal t with index < o_tri_index,
//   load o_t and o_tri_index and set o_hit.
//  Latency: lane input at cycle N is reflected in o_t/o_hit at cycle N+3.
//   o_finish rises 3 cycles after the last granted result.
//  Reset mid-batch: full return to reset state; no o_finish pulse.
// CONFIGURATION
//  Macro CHR_STATS_EN:
//   - defined: adds output o_hit_cnt [IDX_W]. It counts stage-1 candidates in the batch.
//     It is cleared on reset and on i_start, and saturates at all-ones.
//   - undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package chr_pkg:
//   - typedef fip (logic signed [31:0]); FIP_ONE, FIP_MIN, FIP_MAX constants.
//   - typedef chr_state_e {IDLE, RUN, DRAIN, DONE}.
//   - function fip_lt_idx(t_a, i_a, t_b, i_b): tie-broken compare, shared by the tree and the running update.
//  Sub-module chr_min_tree #(NLANES, IDX_W): combinational log2(NLANES)-level min tree.
//   Inputs: candidate mask, t, idx. Outputs: any, t_min, idx_min.
// TESTING
//  1. start, cnt=4; lanes 0..3 valid at once, hit=1111, t={3.0,1.5,2.0,1.5}, idx={10,11,12,13}
//     -> o_t=0x00018000, o_tri_index=11, o_hit=1, o_finish 3 cycles later.
//  2. start, cnt=6; two cycles of 4 valid lanes -> lanes 2,3 of the 2nd cycle dropped, o_err=1, o_finish=1.
//  3. start, cnt=0 -> o_finish=1 next cycle, o_hit=0, o_t=0x7fffffff, o_tri_index=0.
//  4. start, cnt=3; all hits with t={-1.0, 0x7fffffff, 0} and MIN_T=0 -> only t=0 accepted,
//     o_t=0, o_hit=1; with all i_hit=0 -> o_hit=0, o_t=MAX_T.
//  5. start, cnt=8; after 4 results, i_start again with cnt=1 -> prior results discarded;
//     a single result t=5.0, idx=7 -> o_t=0x00050000, o_tri_index=7.
//  6. i_valid=1 while IDLE -> o_err=1 and o_t unchanged; i_rstn=0 mid-RUN -> all outputs return to reset values.
//     With CHR_STATS_EN, scenario 1 -> o_hit_cnt=4.

Source files
------------

// File: rtl/chr_pkg.sv
// Shared types for the closest-hit reducer: Q16.16 fixed-point t, FSM states
// and the tie-broken (t, index) ordering used by both the min tree and the running minimum.
package chr_pkg;

  typedef logic signed [31:0] fip;

  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MIN = 32'sh0000_0000;
  localparam fip FIP_MAX = 32'sh7fff_ffff;

  // Widest triangle index the ordering function accepts; callers size-cast into it.
  localparam int IDX_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chr_state_e;

  // True when (t_a, i_a) orders strictly before (t_b, i_b): smaller t, then smaller index.
  function automatic logic fip_lt_idx(input fip t_a, input logic [IDX_MAX_W-1:0] i_a,
                                      input fip t_b, input logic [IDX_MAX_W-1:0] i_b);
    return (t_a < t_b) || ((t_a == t_b) && (i_a < i_b));
  endfunction

endpackage

// File: rtl/chr_min_tree.sv
// Combinational log2(NLANES)-level min tree over candidate lanes; heap-indexed nodes,
// leaves at NLANES..2*NLANES-1, root at 1. Ties go to the lower triangle index.
module chr_min_tree
  import chr_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int IDX_W  = 32
) (
  input  logic [NLANES-1:0]       cand,
  input  logic [NLANES*32-1:0]    t,
  input  logic [NLANES*IDX_W-1:0] idx,
  output logic                    any,
  output fip                      t_min,
  output logic [IDX_W-1:0]        idx_min
);

  logic             node_any_s [1:2*NLANES-1];
  fip               node_t_s   [1:2*NLANES-1];
  logic [IDX_W-1:0] node_idx_s [1:2*NLANES-1];

  for (genvar k = 0; k < NLANES; k++) begin : g_leaf
    assign node_any_s[NLANES+k] = cand[k];
    assign node_t_s[NLANES+k]   = t[32*k +: 32];
    assign node_idx_s[NLANES+k] = idx[IDX_W*k +: IDX_W];
  end

  for (genvar n = NLANES - 1; n >= 1; n--) begin : g_node
    logic pick_right_s;
    assign pick_right_s = node_any_s[2*n+1] &&
                          (!node_any_s[2*n] ||
                           fip_lt_idx(node_t_s[2*n+1], IDX_MAX_W'(node_idx_s[2*n+1]),
                                      node_t_s[2*n],   IDX_MAX_W'(node_idx_s[2*n])));
    assign node_any_s[n] = node_any_s[2*n] | node_any_s[2*n+1];
    assign node_t_s[n]   = pick_right_s ? node_t_s[2*n+1]   : node_t_s[2*n];
    assign node_idx_s[n] = pick_right_s ? node_idx_s[2*n+1] : node_idx_s[2*n];
  end

  assign any     = node_any_s[1];
  assign t_min   = node_t_s[1];
  assign idx_min = node_idx_s[1];

endmodule

// File: rtl/closest_hit_reducer.sv
// Multi-lane closest-hit tracker for one ray batch: grant, filter, 2-stage min, running minimum.
// Optional macro CHR_STATS_EN adds o_hit_cnt, a saturating per-batch count of accepted candidates.
module closest_hit_reducer
  import chr_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int IDX_W  = 32,
  parameter fip MIN_T  = FIP_MIN,
  parameter fip MAX_T  = FIP_MAX
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [IDX_W-1:0]        i_tri_cnt,
  input  logic [NLANES-1:0]       i_valid,
  input  logic [NLANES-1:0]       i_hit,
  input  logic [NLANES*32-1:0]    i_t,
  input  logic [NLANES*IDX_W-1:0] i_idx,
  output logic                    o_busy,
  output logic                    o_hit,
  output fip                      o_t,
  output logic [IDX_W-1:0]        o_tri_index,
  output logic                    o_finish,
  output logic                    o_err
`ifdef CHR_STATS_EN
  ,
  output logic [IDX_W-1:0]        o_hit_cnt
`endif
);

  chr_state_e             state_r;
  logic [IDX_W-1:0]       remaining_r;
  logic                   drain_r;
  logic                   run_s, drop_s, err_s;
  logic [NLANES-1:0]      grant_s, cand_s;
  logic [IDX_W-1:0]       grant_cnt_s;
  fip                     lane_t_s;
  logic [NLANES-1:0]      s1_cand_r;
  logic [NLANES*32-1:0]   s1_t_r;
  logic [NLANES*IDX_W-1:0] s1_idx_r;
  logic                   tree_any_s, s2_vld_r;
  fip                     tree_t_s, s2_t_r;
  logic [IDX_W-1:0]       tree_idx_s, s2_idx_r;

  // Lane inputs in a start cycle never count as results or errors.
  assign run_s = (state_r == RUN) && !i_start;
  assign err_s = !i_start && (run_s ? drop_s : (|i_valid));

  // Grant valid lanes in ascending order while results are still owed.
  always_comb begin
    grant_s     = {NLANES{1'b0}};
    grant_cnt_s = {IDX_W{1'b0}};
    drop_s      = 1'b0;
    for (int k = 0; k < NLANES; k++) begin
      if (run_s && i_valid[k]) begin
        if (grant_cnt_s < remaining_r) begin
          grant_s[k]  = 1'b1;
          grant_cnt_s = grant_cnt_s + IDX_W'(1'b1);
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        grant_s[k] = 1'b0;
      end
    end
  end

  // Candidate filter: granted hit with MIN_T <= t < MAX_T (signed).
  always_comb begin
    cand_s   = {NLANES{1'b0}};
    lane_t_s = FIP_MIN;
    for (int k = 0; k < NLANES; k++) begin
      lane_t_s = i_t[32*k +: 32];
      if (grant_s[k] && i_hit[k] && (lane_t_s >= MIN_T) && (lane_t_s < MAX_T)) begin
        cand_s[k] = 1'b1;
      end else begin
        cand_s[k] = 1'b0;
      end
    end
  end

  chr_min_tree #(.NLANES(NLANES), .IDX_W(IDX_W)) u_min_tree (
    .cand    (s1_cand_r),
    .t       (s1_t_r),
    .idx     (s1_idx_r),
    .any     (tree_any_s),
    .t_min   (tree_t_s),
    .idx_min (tree_idx_s)
  );

  // Two pipeline stages; a start flushes whatever is in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_start) begin
      s1_cand_r <= {NLANES{1'b0}};
      s1_t_r    <= {(NLANES*32){1'b0}};
      s1_idx_r  <= {(NLANES*IDX_W){1'b0}};
      s2_vld_r  <= 1'b0;
      s2_t_r    <= MAX_T;
      s2_idx_r  <= {IDX_W{1'b0}};
    end else begin
      s1_cand_r <= cand_s;
      s1_t_r    <= i_t;
      s1_idx_r  <= i_idx;
      s2_vld_r  <= tree_any_s;
      s2_t_r    <= tree_t_s;
      s2_idx_r  <= tree_idx_s;
    end
  end

  // Batch FSM with registered status outputs and the running minimum.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r     <= IDLE;
      remaining_r <= {IDX_W{1'b0}};
      drain_r     <= 1'b0;
      o_busy      <= 1'b0;
      o_hit       <= 1'b0;
      o_t         <= MAX_T;
      o_tri_index <= {IDX_W{1'b0}};
      o_finish    <= 1'b0;
      o_err       <= 1'b0;
    end else if (i_start) begin
      remaining_r <= i_tri_cnt;
      drain_r     <= 1'b0;
      o_hit       <= 1'b0;
      o_t         <= MAX_T;
      o_tri_index <= {IDX_W{1'b0}};
      o_err       <= 1'b0;
      if (i_tri_cnt == {IDX_W{1'b0}}) begin
        state_r  <= DONE;
        o_busy   <= 1'b0;
        o_finish <= 1'b1;
      end else begin
        state_r  <= RUN;
        o_busy   <= 1'b1;
        o_finish <= 1'b0;
      end
    end else begin
      o_err <= o_err | err_s;
      if (s2_vld_r && fip_lt_idx(s2_t_r, IDX_MAX_W'(s2_idx_r), o_t, IDX_MAX_W'(o_tri_index))) begin
        o_t         <= s2_t_r;
        o_tri_index <= s2_idx_r;
        o_hit       <= 1'b1;
      end
      case (state_r)
        RUN: begin
          remaining_r <= remaining_r - grant_cnt_s;
          if (grant_cnt_s == remaining_r) begin
            state_r <= DRAIN;
            drain_r <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_r) begin
            state_r  <= DONE;
            o_busy   <= 1'b0;
            o_finish <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        IDLE, DONE: begin
          drain_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHR_STATS_EN
  logic [IDX_W:0] hit_sum_s;

  assign hit_sum_s = (IDX_W+1)'(o_hit_cnt) + (IDX_W+1)'($countones(s1_cand_r));

  // Saturating per-batch count of stage-1 candidates.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_start) begin
      o_hit_cnt <= {IDX_W{1'b0}};
    end else if (hit_sum_s[IDX_W]) begin
      o_hit_cnt <= {IDX_W{1'b1}};
    end else begin
      o_hit_cnt <= hit_sum_s[IDX_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_closest_hit_reducer.sv
// Directed bench for closest_hit_reducer: a result-list model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_closest_hit_reducer;
  import chr_pkg::*;

  localparam int NL = 4;
  localparam int IW = 32;

  logic              i_clk = 1'b0;
  logic              i_rstn;
  logic              i_start;
  logic [IW-1:0]     i_tri_cnt;
  logic [NL-1:0]     i_valid;
  logic [NL-1:0]     i_hit;
  logic [NL*32-1:0]  i_t;
  logic [NL*IW-1:0]  i_idx;
  logic              o_busy, o_hit, o_finish, o_err;
  fip                o_t;
  logic [IW-1:0]     o_tri_index;
`ifdef CHR_STATS_EN
  logic [IW-1:0]     o_hit_cnt;
`endif

  closest_hit_reducer #(.NLANES(NL), .IDX_W(IW)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_start     (i_start),
    .i_tri_cnt   (i_tri_cnt),
    .i_valid     (i_valid),
    .i_hit       (i_hit),
    .i_t         (i_t),
    .i_idx       (i_idx),
    .o_busy      (o_busy),
    .o_hit       (o_hit),
    .o_t         (o_t),
    .o_tri_index (o_tri_index),
    .o_finish    (o_finish),
    .o_err       (o_err)
`ifdef CHR_STATS_EN
    ,
    .o_hit_cnt   (o_hit_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Model: the accepted results of the open batch, each stamped with the edge it was sampled on.
  int            m_edge = 0;
  bit            m_started = 1'b0;
  bit            m_running = 1'b0;
  int            m_fin_edge = -1;
  logic [IW-1:0] m_rem = '0;
  bit            m_err = 1'b0;
  fip            q_t[$];
  logic [IW-1:0] q_idx[$];
  int            q_e[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, m_edge, act, exp);
    end
  endtask

  task automatic clear_batch();
    q_t.delete();
    q_idx.delete();
    q_e.delete();
  endtask

  task automatic model_step();
    fip lt;
    m_edge++;
    if (!i_rstn) begin
      m_started = 1'b0; m_running = 1'b0; m_fin_edge = -1; m_rem = '0; m_err = 1'b0;
      clear_batch();
    end else if (i_start) begin
      m_started = 1'b1; m_rem = i_tri_cnt; m_err = 1'b0;
      clear_batch();
      if (i_tri_cnt == 0) begin
        m_running = 1'b0; m_fin_edge = m_edge;
      end else begin
        m_running = 1'b1; m_fin_edge = -1;
      end
    end else if (m_running) begin
      for (int k = 0; k < NL; k++) begin
        if (i_valid[k]) begin
          if (m_rem != 0) begin
            m_rem--;
            lt = i_t[32*k +: 32];
            if (i_hit[k] && lt >= FIP_MIN && lt < FIP_MAX) begin
              q_t.push_back(lt);
              q_idx.push_back(i_idx[IW*k +: IW]);
              q_e.push_back(m_edge);
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end
      if (m_rem == 0) begin
        m_running = 1'b0;
        m_fin_edge = m_edge + 2;
      end
    end else if (i_valid != 0) begin
      m_err = 1'b1;
    end
  endtask

  task automatic compare();
    bit            any = 1'b0;
    fip            bt = FIP_MAX;
    logic [IW-1:0] bi = '0;
    bit            fin, busy;
    int            hc = 0;
    for (int i = 0; i < q_t.size(); i++) begin
      if (q_e[i] <= m_edge - 2) begin
        if (!any || q_t[i] < bt || (q_t[i] == bt && q_idx[i] < bi)) begin
          any = 1'b1; bt = q_t[i]; bi = q_idx[i];
        end
      end
      if (q_e[i] <= m_edge - 1) hc++;
    end
    fin  = (m_fin_edge >= 0) && (m_edge >= m_fin_edge);
    busy = m_started && !fin;
    chk("busy",   32'(o_busy),   32'(busy));
    chk("hit",    32'(o_hit),    32'(any));
    chk("t",      o_t,           bt);
    chk("index",  o_tri_index,   bi);
    chk("finish", 32'(o_finish), 32'(fin));
    chk("err",    32'(o_err),    32'(m_err));
`ifdef CHR_STATS_EN
    chk("hit_cnt", o_hit_cnt, 32'(hc));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    i_start = 1'b0; i_tri_cnt = '0; i_valid = '0; i_hit = '0;
    i_t = {(NL*32){1'b0}}; i_idx = {(NL*IW){1'b0}};
  endtask

  task automatic lane(input int k, input bit h, input fip t, input logic [IW-1:0] idx);
    i_valid[k] = 1'b1;
    i_hit[k] = h;
    i_t[32*k +: 32] = t;
    i_idx[IW*k +: IW] = idx;
  endtask

  task automatic start(input logic [IW-1:0] cnt);
    clr();
    i_start = 1'b1;
    i_tri_cnt = cnt;
    tick();
    clr();
  endtask

  initial begin
    clr();
    i_rstn = 1'b0;
    ticks(2);
    i_rstn = 1'b1;
    tick();
    chk("lit_reset_t", o_t, 32'h7fff_ffff);
    chk("lit_reset_busy", 32'(o_busy), 32'd0);
    chk("lit_reset_idx", o_tri_index, 32'd0);

    // Four lanes at once, tie at 1.5 between idx 11 and 13.
    start(32'd4);
    lane(0, 1'b1, 32'sh0003_0000, 32'd10);
    lane(1, 1'b1, 32'sh0001_8000, 32'd11);
    lane(2, 1'b1, 32'sh0002_0000, 32'd12);
    lane(3, 1'b1, 32'sh0001_8000, 32'd13);
    tick();
    clr();
    tick();
    chk("lit_s1_finish_early", 32'(o_finish), 32'd0);
    tick();
    chk("lit_s1_finish", 32'(o_finish), 32'd1);
    chk("lit_s1_t", o_t, 32'h0001_8000);
    chk("lit_s1_idx", o_tri_index, 32'd11);
    chk("lit_s1_hit", 32'(o_hit), 32'd1);
`ifdef CHR_STATS_EN
    chk("lit_s1_hit_cnt", o_hit_cnt, 32'd4);
`endif

    // Six expected, eight offered: last two lanes dropped.
    start(32'd6);
    lane(0, 1'b1, 32'sh0004_0000, 32'd0);
    lane(1, 1'b1, 32'sh0005_0000, 32'd1);
    lane(2, 1'b1, 32'sh0006_0000, 32'd2);
    lane(3, 1'b1, 32'sh0007_0000, 32'd3);
    tick();
    clr();
    lane(0, 1'b1, 32'sh0003_0000, 32'd4);
    lane(1, 1'b1, 32'sh0002_8000, 32'd5);
    lane(2, 1'b1, 32'sh0000_8000, 32'd6);
    lane(3, 1'b1, 32'sh0000_4000, 32'd7);
    tick();
    clr();
    ticks(3);
    chk("lit_s2_err", 32'(o_err), 32'd1);
    chk("lit_s2_finish", 32'(o_finish), 32'd1);
    chk("lit_s2_t", o_t, 32'h0002_8000);
    chk("lit_s2_idx", o_tri_index, 32'd5);

    // Empty batch.
    start(32'd0);
    chk("lit_s3_finish", 32'(o_finish), 32'd1);
    chk("lit_s3_hit", 32'(o_hit), 32'd0);
    chk("lit_s3_t", o_t, 32'h7fff_ffff);
    chk("lit_s3_err", 32'(o_err), 32'd0);

    // Range boundaries: t<MIN_T and t==MAX_T rejected, t==MIN_T accepted.
    start(32'd3);
    lane(0, 1'b1, 32'shffff_0000, 32'd20);
    lane(1, 1'b1, 32'sh7fff_ffff, 32'd21);
    lane(2, 1'b1, 32'sh0000_0000, 32'd22);
    tick();
    clr();
    ticks(3);
    chk("lit_s4a_t", o_t, 32'h0000_0000);
    chk("lit_s4a_idx", o_tri_index, 32'd22);
    chk("lit_s4a_hit", 32'(o_hit), 32'd1);
    start(32'd3);
    lane(0, 1'b0, 32'shffff_0000, 32'd20);
    lane(1, 1'b0, 32'sh7fff_ffff, 32'd21);
    lane(2, 1'b0, 32'sh0000_0000, 32'd22);
    tick();
    clr();
    ticks(3);
    chk("lit_s4b_hit", 32'(o_hit), 32'd0);
    chk("lit_s4b_t", o_t, 32'h7fff_ffff);
    chk("lit_s4b_finish", 32'(o_finish), 32'd1);

    // Restart with results in flight.
    start(32'd8);
    lane(0, 1'b1, FIP_ONE, 32'd30);
    lane(1, 1'b1, 32'sh0002_0000, 32'd31);
    lane(2, 1'b1, 32'sh0000_1000, 32'd32);
    lane(3, 1'b1, 32'sh0000_2000, 32'd33);
    tick();
    start(32'd1);
    lane(0, 1'b1, 32'sh0005_0000, 32'd7);
    tick();
    clr();
    ticks(3);
    chk("lit_s5_t", o_t, 32'h0005_0000);
    chk("lit_s5_idx", o_tri_index, 32'd7);
    chk("lit_s5_finish", 32'(o_finish), 32'd1);

    // Sparse lanes with a tie, then a stray result while draining.
    start(32'd2);
    lane(1, 1'b1, 32'sh0002_0000, 32'd9);
    lane(3, 1'b1, 32'sh0002_0000, 32'd4);
    tick();
    clr();
    lane(0, 1'b1, 32'sh0000_0100, 32'd1);
    tick();
    clr();
    ticks(2);
    chk("lit_s7_t", o_t, 32'h0002_0000);
    chk("lit_s7_idx", o_tri_index, 32'd4);
    chk("lit_s7_err", 32'(o_err), 32'd1);

    // Cross-cycle tie: later, lower index wins; later larger t ignored.
    start(32'd4);
    lane(0, 1'b1, FIP_ONE, 32'd50);
    lane(1, 1'b1, 32'sh0002_0000, 32'd51);
    tick();
    clr();
    lane(0, 1'b1, FIP_ONE, 32'd40);
    lane(1, 1'b1, 32'sh0003_0000, 32'd60);
    tick();
    clr();
    ticks(3);
    chk("lit_s8_idx", o_tri_index, 32'd40);
    chk("lit_s8_t", o_t, 32'h0001_0000);

    // Stray result in IDLE, then reset in the middle of a batch.
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    tick();
    lane(0, 1'b1, FIP_ONE, 32'd3);
    tick();
    clr();
    ticks(3);
    chk("lit_s6_err", 32'(o_err), 32'd1);
    chk("lit_s6_t", o_t, 32'h7fff_ffff);
    start(32'd4);
    lane(0, 1'b1, FIP_ONE, 32'd3);
    tick();
    clr();
    ticks(2);
    chk("lit_s6_mid_t", o_t, 32'h0001_0000);
    i_rstn = 1'b0;
    tick();
    chk("lit_s6_rst_busy", 32'(o_busy), 32'd0);
    chk("lit_s6_rst_t", o_t, 32'h7fff_ffff);
    chk("lit_s6_rst_hit", 32'(o_hit), 32'd0);
    i_rstn = 1'b1;
    ticks(3);
    chk("lit_s6_no_finish", 32'(o_finish), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
